// File: rtl/lab5_pkg.sv
// Shared Connect-Four link definitions: column geometry and turn sequencer states.
package lab5_pkg;

    localparam int unsigned NUM_COLS = 7;
    localparam int unsigned COL_W    = 3;

    typedef enum logic [2:0] {
        SYNC,
        LOCAL,
        SEND,
        REMOTE,
        DONE,
        ERROR
    } turn_state_t;

    // A received column is only usable if it names a real column.
    function automatic logic col_legal(input logic [COL_W-1:0] col);
        return col < COL_W'(NUM_COLS);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous GPIO inputs; flops clear to 0 on reset.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/turn_link_controller.sv
// Turn sequencer for a two-board Connect-Four game: syncs with the peer, gates local
// moves into the grid and serial transmitter, and accepts remote moves from the receiver.
module turn_link_controller
    import lab5_pkg::*;
#(
    parameter int unsigned TX_TIMEOUT = 50_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go_first,
    input  logic             ready_in,
    output logic             ready_out,
    input  logic             enter,
    input  logic [COL_W-1:0] local_col,
    output logic             tx_start,
    output logic [COL_W-1:0] tx_col,
    input  logic             tx_done,
    input  logic             rx_valid,
    input  logic [COL_W-1:0] rx_col,
    input  logic             game_over,
    output logic             drop_local,
    output logic             drop_remote,
    output logic [COL_W-1:0] drop_col,
    output logic             my_turn,
    output logic             their_turn,
    output logic             link_error
);

    localparam int unsigned CNT_W = $clog2(TX_TIMEOUT + 1);

    turn_state_t      state;
    turn_state_t      state_nxt;
    logic             rdy_s;
    logic             rdy_q;
    logic [CNT_W-1:0] cnt;

    sync_2ff #(.WIDTH(1)) u_rdy_sync (
        .clk (clk),
        .rst (reset),
        .d   (ready_in),
        .q   (rdy_s)
    );

    // Next state; game_over pre-empts everything except a frame already on the wire.
    always_comb begin
        state_nxt = state;
        unique case (state)
            SYNC: begin
                if (rdy_s && rdy_q) state_nxt = go_first ? LOCAL : REMOTE;
            end
            LOCAL: begin
                if (game_over)   state_nxt = DONE;
                else if (!rdy_s) state_nxt = ERROR;
                else if (enter)  state_nxt = SEND;
            end
            SEND: begin
                if (!rdy_s)                                  state_nxt = ERROR;
                else if (tx_done)                            state_nxt = game_over ? DONE : REMOTE;
                else if (cnt == CNT_W'(TX_TIMEOUT - 1))      state_nxt = ERROR;
            end
            REMOTE: begin
                if (game_over)     state_nxt = DONE;
                else if (!rdy_s)   state_nxt = ERROR;
                else if (rx_valid) state_nxt = col_legal(rx_col) ? LOCAL : ERROR;
            end
            default: state_nxt = state;
        endcase
    end

    // State, timeout counter and registered outputs, all derived from the transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SYNC;
            rdy_q       <= 1'b0;
            cnt         <= '0;
            ready_out   <= 1'b0;
            tx_start    <= 1'b0;
            tx_col      <= '0;
            drop_local  <= 1'b0;
            drop_remote <= 1'b0;
            drop_col    <= '0;
            my_turn     <= 1'b0;
            their_turn  <= 1'b0;
            link_error  <= 1'b0;
        end else begin
            state       <= state_nxt;
            rdy_q       <= rdy_s;
            cnt         <= (state == SEND && state_nxt == SEND) ? cnt + CNT_W'(1) : '0;
            ready_out   <= (state_nxt != DONE) && (state_nxt != ERROR);
            my_turn     <= (state_nxt == LOCAL);
            their_turn  <= (state_nxt == SEND) || (state_nxt == REMOTE);
            link_error  <= (state_nxt == ERROR);
            tx_start    <= (state == LOCAL) && (state_nxt == SEND);
            drop_local  <= (state == LOCAL) && (state_nxt == SEND);
            drop_remote <= (state == REMOTE) && (state_nxt == LOCAL);
            if (state == LOCAL && state_nxt == SEND) begin
                tx_col   <= local_col;
                drop_col <= local_col;
            end else if (state == REMOTE && state_nxt == LOCAL) begin
                drop_col <= rx_col;
            end
        end
    end

endmodule
